pc_sequencer: RTL and testbench

// Program-counter sequencer for the 8-bit single-cycle CPU. Holds the PC, computes
// the next fetch address from PC+4 or a sign-extended, word-scaled 8-bit branch/jump

---
 rtl/pc_sequencer.sv | 115 +++++++++++
 tb/tb_pc_sequencer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: PC register, next-address selection (PC+4 or scaled branch offset),
// stall handling with a latched redirect decision, and a saturating taken-redirect counter.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             busywait,
   input  logic             jump,
   input  logic             branch,
   input  logic             branch_ne,
   input  logic             zero,
   input  logic [7:0]       offset,
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus4,
   output logic             redirect,
   output logic             stalled,
   output logic [CNT_W-1:0] taken_cnt
);

   typedef enum logic [0:0] {RUN = 1'b0, HOLD = 1'b1} state_t;

   state_t           state_r, state_nxt_s;
   logic [31:0]      pc_r, pc_nxt_s, pc_plus4_s, target_s;
   logic [31:0]      pend_tgt_r, pend_tgt_nxt_s;
   logic             pend_take_r, pend_take_nxt_s;
   logic             stalled_r, stalled_nxt_s;
   logic             take_s, redirect_s, cnt_inc_s;
   logic [CNT_W-1:0] cnt_r, cnt_nxt_s;

   function automatic logic [31:0] branch_target(input logic [31:0] base, input logic [7:0] off);
      return base + {{22{off[7]}}, off, 2'b00};
   endfunction

   assign pc_plus4_s = pc_r + 32'd4;
   assign target_s   = branch_target(pc_plus4_s, offset);
   assign take_s     = jump | (branch & zero) | (branch_ne & ~zero);

   // Next-state, next-PC and redirect selection; control inputs only matter in RUN.
   always_comb begin
      state_nxt_s     = state_r;
      pc_nxt_s        = pc_r;
      pend_take_nxt_s = pend_take_r;
      pend_tgt_nxt_s  = pend_tgt_r;
      stalled_nxt_s   = stalled_r;
      cnt_inc_s       = 1'b0;
      redirect_s      = take_s;
      case (state_r)
         RUN: begin
            if (busywait) begin
               pend_take_nxt_s = take_s;
               pend_tgt_nxt_s  = target_s;
               state_nxt_s     = HOLD;
               stalled_nxt_s   = 1'b1;
            end else begin
               pc_nxt_s  = take_s ? target_s : pc_plus4_s;
               cnt_inc_s = take_s;
            end
         end
         HOLD: begin
            redirect_s = pend_take_r;
            if (busywait) begin
               state_nxt_s = HOLD;
            end else begin
               pc_nxt_s      = pend_take_r ? pend_tgt_r : pc_plus4_s;
               cnt_inc_s     = pend_take_r;
               state_nxt_s   = RUN;
               stalled_nxt_s = 1'b0;
            end
         end
         default: begin
            state_nxt_s     = RUN;
            stalled_nxt_s   = 1'b0;
            pend_take_nxt_s = 1'b0;
         end
      endcase
   end

   // Saturating increment of the taken-redirect counter.
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (cnt_inc_s && (cnt_r != {CNT_W{1'b1}})) begin
         cnt_nxt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // State, PC, pending-redirect and counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= RUN;
         pc_r        <= RESET_PC;
         pend_take_r <= 1'b0;
         pend_tgt_r  <= 32'h0000_0000;
         stalled_r   <= 1'b0;
         cnt_r       <= {CNT_W{1'b0}};
      end else begin
         state_r     <= state_nxt_s;
         pc_r        <= pc_nxt_s;
         pend_take_r <= pend_take_nxt_s;
         pend_tgt_r  <= pend_tgt_nxt_s;
         stalled_r   <= stalled_nxt_s;
         cnt_r       <= cnt_nxt_s;
      end
   end

   assign pc        = pc_r;
   assign pc_plus4  = pc_plus4_s;
   assign redirect  = redirect_s;
   assign stalled   = stalled_r;
   assign taken_cnt = cnt_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: an instruction-level model decides each instruction's next PC
// once, commits it when memory is not busy, and queues the expected outputs for a separate monitor.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset, busywait, jump, branch, branch_ne, zero;
   logic [7:0]  offset;
   logic [31:0] pc, pc_plus4, s_pc, s_pc_plus4;
   logic        redirect, stalled, s_redirect, s_stalled;
   logic [15:0] taken_cnt;
   logic [3:0]  s_taken_cnt;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk(clk), .reset(reset), .busywait(busywait), .jump(jump), .branch(branch),
      .branch_ne(branch_ne), .zero(zero), .offset(offset), .pc(pc), .pc_plus4(pc_plus4),
      .redirect(redirect), .stalled(stalled), .taken_cnt(taken_cnt)
   );

   // Narrow-counter instance driven identically, used to reach counter saturation quickly.
   pc_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(4)) u_sat (
      .clk(clk), .reset(reset), .busywait(busywait), .jump(jump), .branch(branch),
      .branch_ne(branch_ne), .zero(zero), .offset(offset), .pc(s_pc), .pc_plus4(s_pc_plus4),
      .redirect(s_redirect), .stalled(s_stalled), .taken_cnt(s_taken_cnt)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] plus4;
      logic        redirect;
      logic        stalled;
      logic [15:0] cnt;
      logic [3:0]  scnt;
   } exp_t;

   exp_t sb_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Instruction-level reference state
   logic [31:0] m_pc;
   bit          m_decided;
   bit          m_take;
   logic [31:0] m_next;
   int          m_cnt;
   int          m_scnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc      = 32'h0000_0000;
      m_decided = 1'b0;
      m_take    = 1'b0;
      m_next    = 32'h0000_0000;
      m_cnt     = 0;
      m_scnt    = 0;
   endtask

   task automatic drive(input bit bw, input bit j, input bit b, input bit bne, input bit z,
                        input logic [7:0] off);
      exp_t e;
      int   soff;
      @(negedge clk);
      busywait = bw; jump = j; branch = b; branch_ne = bne; zero = z; offset = off;
      e.stalled = m_decided;
      if (!m_decided) begin
         soff   = int'($signed(off));
         m_take = j || (b && z) || (bne && !z);
         m_next = m_take ? (m_pc + 32'd4 + 32'(soff * 4)) : (m_pc + 32'd4);
      end
      e.pc       = m_pc;
      e.plus4    = m_pc + 32'd4;
      e.redirect = m_take;
      e.cnt      = 16'(m_cnt);
      e.scnt     = 4'(m_scnt);
      sb_q.push_back(e);
      if (bw) begin
         m_decided = 1'b1;
      end else begin
         m_pc      = m_next;
         m_decided = 1'b0;
         if (m_take) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_scnt < 15) m_scnt++;
         end
      end
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   // Asserts reset mid-cycle, checks the immediate effect, holds it over one posedge.
   task automatic do_reset();
      #3 reset = 1'b1;
      #1;
      chk("rst_pc", pc, 32'h0000_0000);
      chk("rst_stalled", {31'd0, stalled}, 32'd0);
      chk("rst_cnt", {16'd0, taken_cnt}, 32'd0);
      model_reset();
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Monitor: pops the expected response for the current cycle and compares.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("pc", pc, e.pc);
            chk("pc_plus4", pc_plus4, e.plus4);
            chk("redirect", {31'd0, redirect}, {31'd0, e.redirect});
            chk("stalled", {31'd0, stalled}, {31'd0, e.stalled});
            chk("taken_cnt", {16'd0, taken_cnt}, {16'd0, e.cnt});
            chk("sat_cnt", {28'd0, s_taken_cnt}, {28'd0, e.scnt});
         end
      end
   end

   initial begin
      reset = 1'b1; busywait = 1'b0; jump = 1'b0; branch = 1'b0;
      branch_ne = 1'b0; zero = 1'b0; offset = 8'h00;
      model_reset();
      @(posedge clk);
      #1 reset = 1'b0;

      // Sequential fetch, then jump back
      repeat (4) idle();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFE);
      #3 chk("jmp_pre_pc", pc, 32'h0000_0010);
      chk("jmp_redirect", {31'd0, redirect}, 32'd1);
      idle();
      #3 chk("jmp_pc", pc, 32'h0000_000C);
      chk("jmp_cnt", {16'd0, taken_cnt}, 32'd1);
      repeat (4) idle();
      // BEQ taken, then BNE not taken
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h7F);
      #3 chk("beq_pre_pc", pc, 32'h0000_0020);
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h7F);
      #3 chk("beq_pc", pc, 32'h0000_0220);
      chk("bne_redirect", {31'd0, redirect}, 32'd0);
      idle();
      #3 chk("bne_pc", pc, 32'h0000_0224);
      chk("bne_cnt", {16'd0, taken_cnt}, 32'd2);

      // Stall across a taken BEQ with ZERO toggling
      do_reset();
      repeat (16) idle();
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h02);
      #3 chk("stall_pc0", pc, 32'h0000_0040);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h02);
      #3 chk("stall_stalled", {31'd0, stalled}, 32'd1);
      chk("stall_redirect", {31'd0, redirect}, 32'd1);
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h02);
      #3 chk("stall_pc2", pc, 32'h0000_0040);
      idle();
      #3 chk("stall_pc3", pc, 32'h0000_0040);
      idle();
      #3 chk("stall_commit_pc", pc, 32'h0000_004C);
      chk("stall_cnt", {16'd0, taken_cnt}, 32'd1);
      chk("stall_clear", {31'd0, stalled}, 32'd0);

      // Reset during HOLD with a pending jump
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10);
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      do_reset();
      idle();
      #3 chk("hold_rst_pc", pc, 32'h0000_0000);
      // Wrap-around: jump to 0xFFFF_FFFC, then sequential to 0
      drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFD);
      #3 chk("wrap_pre_pc", pc, 32'h0000_0004);
      idle();
      #3 chk("wrap_top", pc, 32'hFFFF_FFFC);
      idle();
      #3 chk("wrap_zero", pc, 32'h0000_0000);
      // Counter saturation on the narrow instance
      repeat (20) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      idle();
      #3 chk("sat_hold", {28'd0, s_taken_cnt}, 32'd15);
      chk("wide_cnt", {16'd0, taken_cnt}, 32'd21);

      // Randomised phase
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            drive($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1, 8'($urandom));
         end
      end

      repeat (2) @(negedge clk);
      #3 chk("queue_drained", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
